// File: rtl/core_seq.sv
// Attention-core instruction sequencer: loads Q/K rows from the host, runs the
// kernel-load and execute phases, then drains, normalises and stores each output row.
module core_seq #(
  parameter int pr      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        fifo_valid,
  output logic [21:0] inst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int RW = (pr > 1) ? $clog2(pr) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam int PMEM_WR  = 0;
  localparam int PMEM_RD  = 1;
  localparam int KMEM_WR  = 2;
  localparam int KMEM_RD  = 3;
  localparam int QMEM_WR  = 4;
  localparam int QMEM_RD  = 5;
  localparam int KLOAD    = 6;
  localparam int EXEC     = 7;
  localparam int OFIFO_RD = 16;
  localparam int DIV      = 17;
  localparam int ACC      = 18;
  localparam int SFP_WR   = 19;

  typedef enum logic [3:0] {
    IDLE, WR_Q, WR_K, K_LOAD, GAP, Q_EXEC, WAIT_F, RD_ROW, NORM, STORE, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] lastRow_q, lastRow_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [21:0]   inst_q, inst_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [3:0]    rowAddr;
  logic          atLast;

  assign rowAddr  = 4'(row_q);
  assign atLast   = (row_q == lastRow_q);
  assign inst     = inst_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);
  assign in_ready = (state_q == WR_Q) || (state_q == WR_K);

  // inst_d is the strobe word for this cycle's action; it is registered so the
  // core sees it one cycle later with no input-to-output combinational path.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    lastRow_d = lastRow_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    done_d    = 1'b0;
    inst_d    = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WR_Q;
          row_d   = '0;
          wdog_d  = '0;
          err_d   = 1'b0;
          if (len == 4'd0)
            lastRow_d = '0;
          else if (int'(len) > pr)
            lastRow_d = RW'(pr - 1);
          else
            lastRow_d = RW'(len - 4'd1);
        end
      end

      WR_Q: begin
        if (in_valid) begin
          inst_d[QMEM_WR] = 1'b1;
          inst_d[15:12]   = rowAddr;
          if (atLast) begin
            row_d   = '0;
            state_d = WR_K;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      WR_K: begin
        if (in_valid) begin
          inst_d[KMEM_WR] = 1'b1;
          inst_d[15:12]   = rowAddr;
          if (atLast) begin
            row_d   = '0;
            state_d = K_LOAD;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      K_LOAD: begin
        inst_d[KMEM_RD] = 1'b1;
        inst_d[KLOAD]   = 1'b1;
        inst_d[15:12]   = rowAddr;
        if (atLast) begin
          row_d   = '0;
          state_d = GAP;
        end else begin
          row_d = row_q + 1'b1;
        end
      end

      // Holds the kernel-load strobe one extra cycle while the last K read lands.
      GAP: begin
        inst_d[KLOAD] = 1'b1;
        state_d       = Q_EXEC;
      end

      Q_EXEC: begin
        inst_d[QMEM_RD] = 1'b1;
        inst_d[EXEC]    = 1'b1;
        inst_d[15:12]   = rowAddr;
        if (atLast) begin
          row_d   = '0;
          wdog_d  = '0;
          state_d = WAIT_F;
        end else begin
          row_d = row_q + 1'b1;
        end
      end

      WAIT_F: begin
        if (fifo_valid) begin
          state_d = RD_ROW;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      RD_ROW: begin
        inst_d[OFIFO_RD] = 1'b1;
        inst_d[ACC]      = 1'b1;
        state_d          = NORM;
      end

      NORM: begin
        inst_d[DIV]    = 1'b1;
        inst_d[SFP_WR] = 1'b1;
        state_d        = STORE;
      end

      STORE: begin
        inst_d[PMEM_WR] = 1'b1;
        inst_d[11:8]    = rowAddr;
        if (atLast) begin
          state_d = DONE;
        end else begin
          row_d = row_q + 1'b1;
          if (fifo_valid) begin
            state_d = RD_ROW;
          end else begin
            wdog_d  = '0;
            state_d = WAIT_F;
          end
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      lastRow_q <= '0;
      wdog_q    <= '0;
      inst_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      lastRow_q <= lastRow_d;
      wdog_q    <= wdog_d;
      inst_q    <= inst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // PMEM_RD is part of the word format but this sequencer never reads pmem.
  logic unusedIdx;
  assign unusedIdx = (PMEM_RD != 1);

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: expected instruction words are built per pass from the
// phase rules and consumed in order as the DUT emits non-zero words.
module tb_core_seq;
  localparam int PR = 8;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  len = 4'd0;
  logic        in_valid = 1'b0;
  logic        fifo_valid = 1'b0;
  logic        in_ready, busy, done, err;
  logic [21:0] inst;

  core_seq #(.pr(PR), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .fifo_valid(fifo_valid),
    .inst(inst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cycleNo = 0;
  int          storesSeen = 0;
  bit          hsAtEdge = 1'b0;
  bit          ivPhase = 1'b1;
  logic [21:0] expQ[$];

  function automatic logic [21:0] qk(input int r);
    return 22'(r) << 12;
  endfunction
  function automatic logic [21:0] qWr(input int r);   return 22'h000010 | qk(r); endfunction
  function automatic logic [21:0] kWr(input int r);   return 22'h000004 | qk(r); endfunction
  function automatic logic [21:0] kLoad(input int r); return 22'h000048 | qk(r); endfunction
  function automatic logic [21:0] qExe(input int r);  return 22'h0000A0 | qk(r); endfunction
  function automatic logic [21:0] store(input int r); return 22'h000001 | (22'(r) << 8); endfunction
  localparam logic [21:0] GAPW  = 22'h000040;
  localparam logic [21:0] RDW   = 22'h050000;
  localparam logic [21:0] NORMW = 22'h0A0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sampled #1 after each rising edge.
  task automatic checkOutput();
    logic wr;
    wr = inst[4] | inst[2];
    check("wr_after_handshake", 32'(wr), 32'(hsAtEdge));
    check("one_write_en", 32'($countones({inst[0], inst[2], inst[4]}) <= 1), 32'd1);
    check("rw_clash", 32'((inst[0] & inst[1]) | (inst[2] & inst[3]) | (inst[4] & inst[5])), 32'd0);
    check("top_bits", 32'(inst[21:20]), 32'd0);
    if (inst !== 22'd0) begin
      if (expQ.size() == 0) check("unexpected_inst", 32'(inst), 32'd0);
      else check("inst_seq", 32'(inst), 32'(expQ.pop_front()));
    end
  endtask

  task automatic tick();
    hsAtEdge = in_valid && in_ready;
    @(posedge clk);
    #1;
    cycleNo++;
    checkOutput();
  endtask

  // ivMode: 0 always 1, 1 toggle 1/0, 2 random.  fvMode: 0 always 1, 1 random, 2 held 0.
  task automatic applyStimulus(input int ivMode, input int fvMode, input bit st);
    start = st;
    case (ivMode)
      0: in_valid = 1'b1;
      1: begin in_valid = ivPhase; ivPhase = ~ivPhase; end
      default: in_valid = 1'($urandom % 2);
    endcase
    case (fvMode)
      0: fifo_valid = 1'b1;
      1: fifo_valid = 1'($urandom % 2);
      default: fifo_valid = 1'b0;
    endcase
  endtask

  task automatic runPass(input int lenIn, input int ivMode, input int fvMode,
                         input bit pokeStart, input bit abortAt3, input bit timing);
    int n, startCyc, c0, doneCyc;
    bit poked, aborted, pokeNow;
    n = (lenIn == 0) ? 1 : ((lenIn > PR) ? PR : lenIn);
    expQ.delete();
    for (int r = 0; r < n; r++) expQ.push_back(qWr(r));
    for (int r = 0; r < n; r++) expQ.push_back(kWr(r));
    for (int r = 0; r < n; r++) expQ.push_back(kLoad(r));
    expQ.push_back(GAPW);
    for (int r = 0; r < n; r++) expQ.push_back(qExe(r));
    if (fvMode != 2)
      for (int r = 0; r < n; r++) begin
        expQ.push_back(RDW);
        expQ.push_back(NORMW);
        expQ.push_back(store(r));
      end

    len = 4'(lenIn);
    start = 1'b1;
    tick();
    startCyc = cycleNo;
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared", 32'(err), 32'd0);
    ivPhase = 1'b1;
    applyStimulus(ivMode, fvMode, 1'b0);

    c0 = -1; doneCyc = -1; storesSeen = 0; poked = 0; aborted = 0;
    for (int k = 0; k < 2000 && doneCyc < 0 && !aborted; k++) begin
      tick();
      pokeNow = 1'b0;
      if (inst[0]) storesSeen++;
      if (inst === qExe(n - 1)) c0 = cycleNo;
      if (fvMode == 2 && c0 >= 0) begin
        if (cycleNo == c0 + TO - 1) check("err_before_timeout", 32'(err), 32'd0);
        if (cycleNo == c0 + TO)     check("err_at_timeout", 32'(err), 32'd1);
      end
      if (pokeStart && !poked && inst[7]) begin
        pokeNow = 1'b1;
        poked = 1'b1;
        len = 4'd3;
      end
      if (done === 1'b1) doneCyc = cycleNo;
      if (abortAt3 && inst === NORMW && storesSeen == 3) begin
        reset = 1'b0;
        #1;
        check("abort_inst", 32'(inst), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        aborted = 1'b1;
        expQ.delete();
      end
      applyStimulus(ivMode, fvMode, pokeNow);
    end

    if (aborted) begin
      start = 1'b0;
      tick();
      tick();
      check("abort_idle", 32'(busy), 32'd0);
      reset = 1'b1;
      return;
    end

    start = 1'b0;
    check("done_seen", 32'(doneCyc >= 0), 32'd1);
    if (timing) check("done_latency", 32'(doneCyc - startCyc), 32'(7 * n + 3));
    if (fvMode == 2) check("done_after_timeout", 32'(doneCyc - c0), 32'(TO + 1));
    check("queue_drained", 32'(expQ.size()), 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("err_level", 32'(err), 32'(fvMode == 2));
  endtask

  initial begin
    #2;
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    $display("[TB] nominal len=8");
    runPass(8, 0, 0, 1'b0, 1'b0, 1'b1);
    $display("[TB] len=1 single-cycle phases");
    runPass(1, 0, 0, 1'b0, 1'b0, 1'b1);
    $display("[TB] host stall len=4");
    runPass(4, 1, 0, 1'b0, 1'b0, 1'b0);
    $display("[TB] boundary len=0 and len=15");
    runPass(0, 0, 0, 1'b0, 1'b0, 1'b1);
    runPass(15, 0, 0, 1'b0, 1'b0, 1'b1);
    $display("[TB] start during Q_EXEC");
    runPass(5, 0, 0, 1'b1, 1'b0, 1'b1);
    $display("[TB] timeout then recovery");
    runPass(3, 2, 2, 1'b0, 1'b0, 1'b0);
    runPass(2, 0, 0, 1'b0, 1'b0, 1'b1);
    $display("[TB] reset during STORE of row 3");
    runPass(8, 0, 0, 1'b0, 1'b1, 1'b0);
    runPass(2, 0, 0, 1'b0, 1'b0, 1'b1);
    $display("[TB] randomized passes");
    for (int p = 0; p < 8; p++)
      runPass(int'($urandom_range(0, 15)), 2, 1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
